div_bus_bridge: RTL and testbench
=================================

# div_bus_bridge

8-bit byte-stream front end for the 16-bit restoring divider. It assembles dividend and divisor from four inbound bus bytes, launches the divider, and waits for completion. It then streams quotient and remainder back out as four bytes. Divide-by-zero and divider timeout are handled locally, so the bus side always gets a response.

## Interface
- TIMEOUT, 64: max cycles to wait for div_ready after div_start before aborting (≥ 20).
- clk  in  1  system clock, all flops rising-edge.
- rst  in  1  asynchronous, active-low reset.
- bus_in  in  8  inbound data byte.
- in_valid  in  1  bus_in holds a valid byte.
- in_ready  out  1  bridge accepts a byte this cycle. A byte transfers on an edge with in_valid & in_ready.
- bus_out  out  8  outbound data byte, registered.
- out_valid  out  1  bus_out holds a valid byte, registered.
- out_ready  in  1  consumer accepts a byte. A byte transfers on an edge with out_valid & out_ready.
- div_A  out  16  dividend to divider, registered.
- div_B  out  16  divisor to divider, registered.
- div_start  out  1  one-cycle start pulse to divider.
- div_ready  in  1  divider completion; level, sampled as described below.
- div_Q  in  16  divider quotient.
- div_R  in  16  divider remainder.
- div0  out  1  current result is a divide-by-zero substitute.
- tout  out  1  current result is a timeout substitute.
- busy  out  1  high in every state except LOAD_A0.

## Operation
- State machine with states LOAD_A0, LOAD_A1, LOAD_B0, LOAD_B1, START, WAIT, SEND_Q0, SEND_Q1, SEND_R0, SEND_R1.
- Input byte order is A low, A high, B low, B high. Each accepted byte is written into its div_A/div_B half and advances the state by one.
- in_ready = 1 exactly in the LOAD_* states. It is decoded from state only, with no dependence on in_valid.
- On accepting B high:
  - If the full 16-bit B is 0, go straight to SEND_Q0 with result Q=16'hFFFF, R=div_A and div0=1. No div_start is issued.
  - Otherwise go to START.
- START lasts one cycle with div_start=1, then goes to WAIT. The cycle counter is cleared on entry to WAIT.
- WAIT ignores div_ready in its first cycle, since the divider drops ready within one cycle of start.
- From the second WAIT cycle onward, div_ready=1 captures div_Q/div_R into the result register and moves to SEND_Q0.
- If the counter reaches TIMEOUT without div_ready, go to SEND_Q0 with result Q=16'hFFFF, R=16'hFFFF and tout=1.
- If div_ready and the timeout hit in the same cycle, div_ready wins and tout=0.
- Output byte order is Q low, Q high, R low, R high. out_valid=1 in the SEND_* states.
- bus_out is held stable until its byte is accepted. After R high is accepted, return to LOAD_A0.
- div0 and tout stay stable through the SEND_* states and clear on entry to LOAD_A0.
- Operands are raw 16-bit two's-complement bit patterns. The bridge does no sign handling; the divider owns signed semantics.

## Timing
- Reset values while rst=0:
  - State is LOAD_A0.
  - Registered outputs are cleared: bus_out=0, out_valid=0, div_A=0, div_B=0, div_start=0, div0=0, tout=0.
  - State-decoded outputs follow the reset state: in_ready=1, busy=0.
- Reset asserted mid-transaction discards partial operands and any pending result, and deasserts div_start immediately. The next accepted byte is A low.
- Input-side throughput is one byte per cycle with in_valid held high. Back-pressure is honoured at any byte.
- The last input byte is accepted at edge N. div_start is high during cycle N+1.
- div_ready is first seen in WAIT at edge M. out_valid is high with Q low during cycle M+1.
- Divide-by-zero: out_valid is high the cycle after the B high edge.
- Output side: one byte per cycle when out_ready is held high. Minimum total output latency is 4 cycles.
- in_ready stays low from START until the return to LOAD_A0. A new transaction never overlaps the current one.
- Exactly one div_start pulse is issued per non-zero-divisor transaction.

## Test plan
- Bench uses a divider stub with programmable latency L (default 17 cycles), which returns Q=A/B and R=A%B.
- Bytes 19 00 05 00: div_A=0x0019, div_B=0x0005, one div_start, outputs 05 00 00 00, div0=0, tout=0.
- Bytes CE FF 07 00 (A=-50): div_A=16'hFFCE, div_B=16'h0007. Output bytes equal the stub Q/R, low byte first.
- Bytes 17 00 00 00 (B=0): no div_start, outputs FF FF 17 00, div0=1. div0 clears on return to LOAD_A0.
- Back-pressure:
  - in_valid gaps of 3 cycles between input bytes still yield div_A=0x0064, div_B=0x0019 and outputs 04 00 00 00.
  - Holding out_ready low for 5 cycles during Q high keeps bus_out=00 and out_valid=1 stable; no byte is lost or duplicated.
- Timeout: stub never asserts div_ready, TIMEOUT=64. The bridge leaves WAIT exactly 64 cycles after entry and outputs FF FF FF FF with tout=1. A new transaction afterwards completes normally.
- Reset mid-operation: pull rst low after 2 input bytes, and separately during WAIT. Outputs take reset values, and the next 4 bytes 08 00 02 00 give outputs 04 00 00 00.

Source files
------------

// File: rtl/div_bus_bridge.sv
// rtl/div_bus_bridge.sv - byte-stream front end for the 16-bit restoring divider
// Collects A/B from four bus bytes, runs the divider, returns Q/R as four bytes.
module div_bus_bridge #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  bus_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  bus_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] div_A,
    output logic [15:0] div_B,
    output logic        div_start,
    input  logic        div_ready,
    input  logic [15:0] div_Q,
    input  logic [15:0] div_R,
    output logic        div0,
    output logic        tout,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [3:0] {
        LOAD_A0, LOAD_A1, LOAD_B0, LOAD_B1, START, WAIT,
        SEND_Q0, SEND_Q1, SEND_R0, SEND_R1
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   a_q, a_d, b_q, b_d;
    logic [15:0]   res_q_q, res_q_d, res_r_q, res_r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          div0_q, div0_d, tout_q, tout_d;
    logic          start_q, start_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    bus_out_q, bus_out_d;
    logic          in_fire, out_fire;

    assign in_ready  = (state_q == LOAD_A0) || (state_q == LOAD_A1) ||
                       (state_q == LOAD_B0) || (state_q == LOAD_B1);
    assign busy      = (state_q != LOAD_A0);
    assign in_fire   = in_ready & in_valid;
    assign out_fire  = out_valid_q & out_ready;

    assign bus_out   = bus_out_q;
    assign out_valid = out_valid_q;
    assign div_A     = a_q;
    assign div_B     = b_q;
    assign div_start = start_q;
    assign div0      = div0_q;
    assign tout      = tout_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_q_d = res_q_q;
        res_r_d = res_r_q;
        cnt_d   = cnt_q;
        div0_d  = div0_q;
        tout_d  = tout_q;
        case (state_q)
            LOAD_A0: if (in_fire) begin a_d[7:0]  = bus_in; state_d = LOAD_A1; end
            LOAD_A1: if (in_fire) begin a_d[15:8] = bus_in; state_d = LOAD_B0; end
            LOAD_B0: if (in_fire) begin b_d[7:0]  = bus_in; state_d = LOAD_B1; end
            LOAD_B1: begin
                if (in_fire) begin
                    b_d[15:8] = bus_in;
                    if ({bus_in, b_q[7:0]} == 16'h0000) begin
                        res_q_d = 16'hFFFF;
                        res_r_d = a_q;
                        div0_d  = 1'b1;
                        state_d = SEND_Q0;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // The first WAIT cycle may still see the previous ready level.
                if ((cnt_q != '0) && div_ready) begin
                    res_q_d = div_Q;
                    res_r_d = div_R;
                    state_d = SEND_Q0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_q_d = 16'hFFFF;
                    res_r_d = 16'hFFFF;
                    tout_d  = 1'b1;
                    state_d = SEND_Q0;
                end
            end
            SEND_Q0: if (out_fire) state_d = SEND_Q1;
            SEND_Q1: if (out_fire) state_d = SEND_R0;
            SEND_R0: if (out_fire) state_d = SEND_R1;
            SEND_R1: begin
                if (out_fire) begin
                    div0_d  = 1'b0;
                    tout_d  = 1'b0;
                    state_d = LOAD_A0;
                end
            end
            default: state_d = LOAD_A0;
        endcase

        // Registered outputs are decoded from the next state so they line up with it.
        start_d     = (state_d == START);
        out_valid_d = 1'b1;
        case (state_d)
            SEND_Q0: bus_out_d = res_q_d[7:0];
            SEND_Q1: bus_out_d = res_q_d[15:8];
            SEND_R0: bus_out_d = res_r_d[7:0];
            SEND_R1: bus_out_d = res_r_d[15:8];
            default: begin
                bus_out_d   = 8'h00;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LOAD_A0;
            a_q         <= '0;
            b_q         <= '0;
            res_q_q     <= '0;
            res_r_q     <= '0;
            cnt_q       <= '0;
            div0_q      <= 1'b0;
            tout_q      <= 1'b0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            bus_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q_q     <= res_q_d;
            res_r_q     <= res_r_d;
            cnt_q       <= cnt_d;
            div0_q      <= div0_d;
            tout_q      <= tout_d;
            start_q     <= start_d;
            out_valid_q <= out_valid_d;
            bus_out_q   <= bus_out_d;
        end
    end

endmodule

// File: tb/tb_div_bus_bridge.sv
// tb/tb_div_bus_bridge.sv - scoreboard bench for div_bus_bridge with a divider stub
module tb_div_bus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  bus_in = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  bus_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] div_A, div_B;
    logic        div_start;
    logic        div_ready;
    logic [15:0] div_Q, div_R;
    logic        div0, tout, busy;

    int n_assert = 0;
    int n_fail   = 0;
    int starts   = 0;
    int stub_lat = 17;
    bit never_ready = 1'b0;

    typedef struct {
        logic [7:0] b;
        logic       d0;
        logic       to;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    div_bus_bridge #(.TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .in_valid(in_valid), .in_ready(in_ready),
        .bus_out(bus_out), .out_valid(out_valid), .out_ready(out_ready),
        .div_A(div_A), .div_B(div_B), .div_start(div_start), .div_ready(div_ready),
        .div_Q(div_Q), .div_R(div_R), .div0(div0), .tout(tout), .busy(busy)
    );

    // Divider stub: signed Q/R after stub_lat cycles, ready drops on start.
    int stub_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_ready <= 1'b1;
            stub_cnt  <= 0;
            div_Q     <= 16'h0000;
            div_R     <= 16'h0000;
        end else if (div_start) begin
            div_ready <= 1'b0;
            stub_cnt  <= stub_lat;
            if (div_B != 16'h0000) begin
                div_Q <= $signed(div_A) / $signed(div_B);
                div_R <= $signed(div_A) % $signed(div_B);
            end
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && !never_ready) div_ready <= 1'b1;
        end
    end

    always @(posedge clk) if (rst && div_start) starts <= starts + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_res(input logic [15:0] q, input logic [15:0] r, input logic d0, input logic to);
        exp_t e;
        e.d0 = d0; e.to = to;
        e.b = q[7:0];  sb.push_back(e);
        e.b = q[15:8]; sb.push_back(e);
        e.b = r[7:0];  sb.push_back(e);
        e.b = r[15:8]; sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus_in = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic recv4(input int stall_idx);
        exp_t e;
        int   n;
        for (int i = 0; i < 4; i++) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'(sb.size()), 32'd4);
                return;
            end
            e = sb.pop_front();
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("out_valid_wait", 32'(out_valid), 32'd1);
            if (i == stall_idx) begin
                for (int k = 0; k < 5; k++) begin
                    out_ready = 1'b0;
                    chk("stall_bus_out", 32'(bus_out), 32'(e.b));
                    chk("stall_out_valid", 32'(out_valid), 32'd1);
                    @(negedge clk);
                end
            end
            out_ready = 1'b1;
            chk("bus_out", 32'(bus_out), 32'(e.b));
            chk("div0", 32'(div0), 32'(e.d0));
            chk("tout", 32'(tout), 32'(e.to));
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_bus_out", 32'(bus_out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_div_A", 32'(div_A), 32'd0);
        chk("rst_div_B", 32'(div_B), 32'd0);
        chk("rst_div_start", 32'(div_start), 32'd0);
        chk("rst_div0", 32'(div0), 32'd0);
        chk("rst_tout", 32'(tout), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    function automatic logic [15:0] sdiv(input logic [15:0] a, input logic [15:0] b);
        return $signed(a) / $signed(b);
    endfunction

    function automatic logic [15:0] smod(input logic [15:0] a, input logic [15:0] b);
        return $signed(a) % $signed(b);
    endfunction

    task automatic run_txn(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input int gap, input int stall_idx);
        logic [15:0] a, b;
        int s0, n;
        a = {b1, b0};
        b = {b3, b2};
        if (b == 16'h0000)  push_res(16'hFFFF, a, 1'b1, 1'b0);
        else if (never_ready) push_res(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        else                push_res(sdiv(a, b), smod(a, b), 1'b0, 1'b0);
        s0 = starts;
        send_byte(b0); repeat (gap) @(posedge clk);
        send_byte(b1); repeat (gap) @(posedge clk);
        send_byte(b2); repeat (gap) @(posedge clk);
        send_byte(b3);
        @(negedge clk);
        chk("div_A", 32'(div_A), 32'(a));
        chk("div_B", 32'(div_B), 32'(b));
        if (b != 16'h0000) begin
            chk("start_pulse", 32'(div_start), 32'd1);
            chk("in_ready_start", 32'(in_ready), 32'd0);
            chk("busy_start", 32'(busy), 32'd1);
        end else begin
            chk("div0_out_valid", 32'(out_valid), 32'd1);
            chk("div0_no_start", 32'(div_start), 32'd0);
            chk("div0_flag", 32'(div0), 32'd1);
        end
        if (never_ready) begin
            n = 0;
            while (!out_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_latency", 32'(n), 32'd65);
        end
        recv4(stall_idx);
        @(negedge clk);
        chk("idle_div0", 32'(div0), 32'd0);
        chk("idle_tout", 32'(tout), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("start_count", 32'(starts - s0), (b != 16'h0000) ? 32'd1 : 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b1;

        run_txn(8'h19, 8'h00, 8'h05, 8'h00, 0, -1);
        run_txn(8'hCE, 8'hFF, 8'h07, 8'h00, 0, -1);
        run_txn(8'h17, 8'h00, 8'h00, 8'h00, 0, -1);
        run_txn(8'h64, 8'h00, 8'h19, 8'h00, 3, 1);

        never_ready = 1'b1;
        run_txn(8'h2A, 8'h00, 8'h03, 8'h00, 0, -1);
        never_ready = 1'b0;
        run_txn(8'h2A, 8'h00, 8'h03, 8'h00, 0, -1);

        // Reset after two input bytes.
        send_byte(8'h55);
        send_byte(8'h66);
        @(negedge clk);
        rst = 1'b0;
        #1 chk_reset_vals();
        @(negedge clk);
        rst = 1'b1;
        run_txn(8'h08, 8'h00, 8'h02, 8'h00, 0, -1);

        // Reset while waiting on the divider.
        stub_lat = 30;
        send_byte(8'h64);
        send_byte(8'h00);
        send_byte(8'h19);
        send_byte(8'h00);
        repeat (6) @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1 chk_reset_vals();
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        stub_lat = 17;
        run_txn(8'h08, 8'h00, 8'h02, 8'h00, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "global timeout");
    end

endmodule
